// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Define MDU_HILO_WRITE_EN to enable direct HI/LO writes (mthi/mtlo).
module mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             oper,
    input  logic             sign,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             we_hi,
    input  logic             we_lo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   bmag;
    logic [WIDTH-1:0]   araw;
    logic               op;
    logic               sgn;
    logic               an;
    logic               bn;
    logic               bzero;

    logic [WIDTH-1:0]   amag_in;
    logic [WIDTH-1:0]   bmag_in;
    logic [WIDTH:0]     madd;
    logic [WIDTH:0]     dtrial;
    logic [WIDTH:0]     dsub;
    logic [2*WIDTH-1:0] mul_next;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

`ifndef MDU_HILO_WRITE_EN
    logic unused_wr;
    assign unused_wr = ^{we_hi, we_lo, wdata};
`endif

    assign busy = (state_q != IDLE);

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = CALC;
            CALC:    if (cnt == CW'(WIDTH - 1)) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        amag_in = (sign && a[WIDTH-1]) ? -a : a;
        bmag_in = (sign && b[WIDTH-1]) ? -b : b;
    end

    // Both modes keep the working operand in acc[WIDTH-1:0] and the
    // partial product / partial remainder in the upper half.
    always_comb begin
        madd     = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, bmag};
        mul_next = acc[0] ? {madd, acc[WIDTH-1:1]}
                          : {1'b0, acc[2*WIDTH-1:1]};
        dtrial   = acc[2*WIDTH-1:WIDTH-1];
        dsub     = dtrial - {1'b0, bmag};
        div_next = dsub[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                               : {dsub[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end

    always_comb begin
        prod   = (sgn && (an ^ bn)) ? -acc : acc;
        res_hi = prod[2*WIDTH-1:WIDTH];
        res_lo = prod[WIDTH-1:0];
        if (op) begin
            if (bzero) begin
                res_lo = '1;
                res_hi = araw;
            end else begin
                res_lo = (sgn && (an ^ bn)) ? -acc[WIDTH-1:0]
                                            : acc[WIDTH-1:0];
                res_hi = (sgn && an) ? -acc[2*WIDTH-1:WIDTH]
                                     : acc[2*WIDTH-1:WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            acc   <= '0;
            bmag  <= '0;
            araw  <= '0;
            op    <= 1'b0;
            sgn   <= 1'b0;
            an    <= 1'b0;
            bn    <= 1'b0;
            bzero <= 1'b0;
            done  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        op    <= oper;
                        sgn   <= sign;
                        an    <= sign & a[WIDTH-1];
                        bn    <= sign & b[WIDTH-1];
                        araw  <= a;
                        bmag  <= bmag_in;
                        bzero <= (b == '0);
                        acc   <= {{WIDTH{1'b0}}, amag_in};
                        cnt   <= '0;
                    end
`ifdef MDU_HILO_WRITE_EN
                    else begin
                        if (we_hi) hi <= wdata;
                        if (we_lo) lo <= wdata;
                    end
`endif
                end
                CALC: begin
                    acc <= op ? div_next : mul_next;
                    cnt <= cnt + CW'(1);
                end
                FIX: begin
                    hi   <= res_hi;
                    lo   <= res_lo;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// Testbench for mdu_iter (WIDTH=32): directed and random ops vs. an
// arithmetic reference model, latency, back-to-back, reset and HI/LO writes.
module tb_mdu_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        oper;
    logic        sign;
    logic [31:0] a;
    logic [31:0] b;
    logic        we_hi;
    logic        we_lo;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int nchk = 0;
    int nerr = 0;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;

    always #5 clk = ~clk;

    mdu_iter #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .oper  (oper),
        .sign  (sign),
        .a     (a),
        .b     (b),
        .we_hi (we_hi),
        .we_lo (we_lo),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] expv);
        nchk++;
        assert (obs === expv) else begin
            nerr++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // {hi, lo} as defined by the arithmetic rules.
    function automatic logic [63:0] model(input logic op, input logic sg,
                                          input logic [31:0] x,
                                          input logic [31:0] y);
        longint p;
        int q;
        int r;
        logic [63:0] u;
        if (!op) begin
            if (sg) begin
                p = longint'($signed(x)) * longint'($signed(y));
                return p;
            end
            u = {32'b0, x} * {32'b0, y};
            return u;
        end
        if (y == 32'd0) return {x, 32'hFFFFFFFF};
        if (sg) begin
            if (x == 32'h80000000 && y == 32'hFFFFFFFF)
                return {32'd0, 32'h80000000};
            q = $signed(x) / $signed(y);
            r = $signed(x) % $signed(y);
            return {r, q};
        end
        return {x % y, x / y};
    endfunction

    // Called just after a negedge with the DUT idle or in its done cycle;
    // returns at the negedge of the done cycle.
    // poke: 0 none, 1 extra start mid-op, 2 HI/LO write mid-op.
    task automatic run_op(input string tag, input logic op, input logic sg,
                          input logic [31:0] x, input logic [31:0] y,
                          input int poke);
        int cyc;
        int bc;
        logic [63:0] r;
        r = model(op, sg, x, y);
        start = 1'b1;
        oper  = op;
        sign  = sg;
        a     = x;
        b     = y;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        oper  = ~op;
        sign  = ~sg;
        cyc   = 1;
        bc    = 0;
        chk({tag, " busy_first"}, {63'd0, busy}, 64'd1);
        while (!done && cyc < 100) begin
            if (busy) bc++;
            @(negedge clk);
            cyc++;
            if (cyc == 5 && poke == 1) begin
                start = 1'b1;
                oper  = 1'b1;
                sign  = 1'b0;
                a     = 32'd9;
                b     = 32'd3;
            end else if (cyc == 5 && poke == 2) begin
                we_hi = 1'b1;
                we_lo = 1'b1;
                wdata = 32'h12345678;
            end else if (cyc == 6) begin
                start = 1'b0;
                we_hi = 1'b0;
                we_lo = 1'b0;
                if (poke != 0)
                    chk({tag, " hilo_hold"}, {hi, lo}, {exp_hi, exp_lo});
            end
        end
        chk({tag, " latency"}, 64'(cyc), 64'd34);
        chk({tag, " busy_cycles"}, 64'(bc), 64'd33);
        chk({tag, " busy_at_done"}, {63'd0, busy}, 64'd0);
        chk({tag, " hi"}, {32'd0, hi}, {32'd0, r[63:32]});
        chk({tag, " lo"}, {32'd0, lo}, {32'd0, r[31:0]});
        exp_hi = r[63:32];
        exp_lo = r[31:0];
    endtask

    initial begin
        int cyc;
        logic [31:0] x;
        logic [31:0] y;
        rst   = 1'b1;
        start = 1'b0;
        oper  = 1'b0;
        sign  = 1'b0;
        a     = '0;
        b     = '0;
        we_hi = 1'b0;
        we_lo = 1'b0;
        wdata = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset busy", {63'd0, busy}, 64'd0);
        chk("reset done", {63'd0, done}, 64'd0);
        chk("reset hilo", {hi, lo}, 64'd0);
        exp_hi = '0;
        exp_lo = '0;

        run_op("smul -2*3", 1'b0, 1'b1, 32'hFFFFFFFE, 32'd3, 0);
        run_op("umul -2*3", 1'b0, 1'b0, 32'hFFFFFFFE, 32'd3, 0);
        run_op("sdiv -7/2", 1'b1, 1'b1, 32'hFFFFFFF9, 32'd2, 0);
        run_op("udiv 100/7", 1'b1, 1'b0, 32'd100, 32'd7, 0);
        run_op("udiv by0", 1'b1, 1'b0, 32'h12345678, 32'd0, 0);
        run_op("sdiv by0", 1'b1, 1'b1, 32'hFFFFFFF0, 32'd0, 0);
        run_op("sdiv ovf", 1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, 0);
        run_op("smul minmin", 1'b0, 1'b1, 32'h80000000, 32'h80000000, 0);
        run_op("umul maxmax", 1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        run_op("ignored start", 1'b0, 1'b0, 32'd1234, 32'd5678, 1);
        run_op("b2b", 1'b1, 1'b1, 32'd7, 32'hFFFFFFFE, 0);

        for (int i = 0; i < 24; i++) begin
            x = $urandom;
            y = $urandom;
            if (i % 4 == 1) y = $urandom_range(0, 9);
            if (i % 4 == 2) y = -$urandom_range(1, 9);
            run_op($sformatf("rand%0d", i), 1'(i % 2), 1'(i / 2 % 2),
                   x, y, 0);
        end

        // Reset in the middle of CALC discards the operation.
        start = 1'b1;
        oper  = 1'b0;
        sign  = 1'b0;
        a     = 32'd77;
        b     = 32'd88;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst busy", {63'd0, busy}, 64'd0);
        chk("midrst done", {63'd0, done}, 64'd0);
        chk("midrst hilo", {hi, lo}, 64'd0);
        exp_hi = '0;
        exp_lo = '0;
        cyc = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) cyc++;
        end
        chk("midrst no_done", 64'(cyc), 64'd0);

        // Direct HI/LO writes while idle.
        we_hi = 1'b1;
        wdata = 32'hCAFEF00D;
        @(negedge clk);
        we_hi = 1'b0;
`ifdef MDU_HILO_WRITE_EN
        exp_hi = 32'hCAFEF00D;
`endif
        chk("we_hi idle", {32'd0, hi}, {32'd0, exp_hi});
        we_lo = 1'b1;
        wdata = 32'h0BADBEEF;
        @(negedge clk);
        we_lo = 1'b0;
`ifdef MDU_HILO_WRITE_EN
        exp_lo = 32'h0BADBEEF;
`endif
        chk("we_lo idle", {32'd0, lo}, {32'd0, exp_lo});
        we_hi = 1'b1;
        we_lo = 1'b1;
        wdata = 32'h55AA33CC;
        start = 1'b0;
        @(negedge clk);
        we_hi = 1'b0;
        we_lo = 1'b0;
`ifdef MDU_HILO_WRITE_EN
        exp_hi = 32'h55AA33CC;
        exp_lo = 32'h55AA33CC;
`endif
        chk("we both idle", {hi, lo}, {exp_hi, exp_lo});

        run_op("we during busy", 1'b0, 1'b1, 32'hFFFFFFFB, 32'd6, 2);

        // A write strobe coincident with start is ignored.
        we_hi = 1'b1;
        wdata = 32'hDEADDEAD;
        run_op("we with start", 1'b1, 1'b0, 32'd1000, 32'd33, 0);
        we_hi = 1'b0;
        @(negedge clk);
        chk("hold after done", {hi, lo}, {exp_hi, exp_lo});

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
